// File: rtl/mips_harvard_mem_responder.sv
// Memory-side responder for the Harvard MIPS CPU: instruction ROM and data
// RAM with combinational reads, single-cycle data writes, a side preload
// port, a programmable clk_enable stall generator, a sticky protocol-error
// flag and a count of committed CPU data writes.
module mips_harvard_mem_responder #(
    parameter logic [31:0] INSTR_BASE   = 32'hBFC00000,
    parameter int          INSTR_WORDS  = 256,
    parameter logic [31:0] DATA_BASE    = 32'h00000000,
    parameter int          DATA_WORDS   = 1024,
    parameter int          STALL_PERIOD = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        clk_enable,
    input  logic        load_en,
    input  logic        load_sel,
    input  logic [31:0] load_word,
    input  logic [31:0] load_data,
    output logic        error,
    output logic [31:0] write_count
);

    localparam int          IW          = $clog2(INSTR_WORDS);
    localparam int          DW          = $clog2(DATA_WORDS);
    localparam logic [31:0] INSTR_BYTES = 32'(4 * INSTR_WORDS);
    localparam logic [31:0] DATA_BYTES  = 32'(4 * DATA_WORDS);

    logic [31:0] r_rom [INSTR_WORDS];
    logic [31:0] r_ram [DATA_WORDS];
    logic        r_error;
    logic [31:0] r_write_count;

    // Offsets from the region base; an address below the base wraps to a
    // huge offset, so a single unsigned compare covers both range bounds.
    logic [31:0]   w_i_off;
    logic [31:0]   w_d_off;
    logic          w_i_ok;
    logic          w_d_ok;
    logic [IW-1:0] w_i_idx;
    logic [DW-1:0] w_d_idx;
    logic [DW-1:0] w_l_idx;
    logic          w_load_ram;
    logic          w_load_rom;
    logic          w_load_clash;
    logic          w_err_now;
    logic          w_commit;
    logic          w_unused_load;

    assign w_i_off  = instr_address - INSTR_BASE;
    assign w_d_off  = data_address - DATA_BASE;
    assign w_i_ok   = (w_i_off < INSTR_BYTES) && (w_i_off[1:0] == 2'b00);
    assign w_d_ok   = (w_d_off < DATA_BYTES) && (w_d_off[1:0] == 2'b00);
    assign w_i_idx  = w_i_off[IW+1:2];
    assign w_d_idx  = w_d_off[DW+1:2];
    assign w_l_idx  = load_word[DW-1:0];

    assign w_load_ram   = load_en && load_sel;
    assign w_load_rom   = load_en && !load_sel;
    assign w_load_clash = w_load_ram && (w_l_idx == w_d_idx);

    // Preload word index is taken modulo depth; the high bits are ignored.
    assign w_unused_load = ^load_word[31:DW];

    assign w_err_now = !reset &&
                       ((((data_read || data_write) && !w_d_ok)) ||
                        (data_read && data_write));

    // A preload to the same word wins, so the CPU write is dropped entirely.
    assign w_commit = data_write && w_d_ok && !data_read && clk_enable &&
                      !reset && !w_load_clash;

    assign instr_readdata = w_i_ok ? r_rom[w_i_idx] : 32'h0;
    assign data_readdata  = (data_read && w_d_ok) ? r_ram[w_d_idx] : 32'h0;
    assign error          = r_error;
    assign write_count    = r_write_count;

    // Instruction ROM is written only through the preload port.
    always_ff @(posedge clk) begin
        if (w_load_rom) begin
            r_rom[load_word[IW-1:0]] <= load_data;
        end
    end

    // Data RAM: CPU commit and preload; they never hit the same word here.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_ram[w_d_idx] <= data_writedata;
        end
        if (w_load_ram) begin
            r_ram[w_l_idx] <= load_data;
        end
    end

    // Sticky protocol-error flag and committed-write counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error       <= 1'b0;
            r_write_count <= 32'h0;
        end else begin
            if (w_err_now) begin
                r_error <= 1'b1;
            end
            if (w_commit) begin
                r_write_count <= r_write_count + 32'h1;
            end
        end
    end

    generate
        if (STALL_PERIOD >= 2) begin : g_stall
            logic [31:0] r_stall_cnt;

            // Free-running 0..STALL_PERIOD-1 counter; last count is the stall.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_stall_cnt <= 32'h0;
                end else if (r_stall_cnt == 32'(STALL_PERIOD - 1)) begin
                    r_stall_cnt <= 32'h0;
                end else begin
                    r_stall_cnt <= r_stall_cnt + 32'h1;
                end
            end

            assign clk_enable = (r_stall_cnt != 32'(STALL_PERIOD - 1));
        end else begin : g_no_stall
            assign clk_enable = 1'b1;
        end
    endgenerate

endmodule
